// File: rtl/f16_dot_seq_if.sv
// Handshake and FMAC-side signal bundle for the sequential FP16 dot-product engine.
interface f16_dot_seq_if #(
  parameter int LEN_W = 5
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic [15:0]      init_z;
  logic             in_valid;
  logic [15:0]      in_x;
  logic [15:0]      in_y;
  logic             in_ready;
  logic [15:0]      fmac_x;
  logic [15:0]      fmac_y;
  logic [15:0]      fmac_z;
  logic [15:0]      fmac_result;
  logic             out_valid;
  logic [15:0]      out_data;
  logic             out_ready;
  logic             busy;
  logic             ovf;

  modport master (
    output start, len, init_z, in_valid, in_x, in_y, fmac_result, out_ready,
    input  in_ready, fmac_x, fmac_y, fmac_z, out_valid, out_data, busy, ovf
  );

  modport slave (
    input  start, len, init_z, in_valid, in_x, in_y, fmac_result, out_ready,
    output in_ready, fmac_x, fmac_y, fmac_z, out_valid, out_data, busy, ovf
  );
endinterface

// File: rtl/f16_dot_seq.sv
// Sequential FP16 dot product: feeds one x*y pair per two cycles to an external
// combinational FMAC and accumulates the result, flagging any all-ones exponent.
module f16_dot_seq #(
  parameter int LEN_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  f16_dot_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_MAC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {(LEN_W-1){1'b0}}};

  state_t           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] tgt_q, tgt_d;
  logic [15:0]      fx_q, fx_d;
  logic [15:0]      fy_q, fy_d;
  logic [15:0]      fz_q, fz_d;
  logic             ovf_q, ovf_d;

  logic [LEN_W-1:0] len_sat;
  logic [LEN_W-1:0] cnt_inc;
  logic             in_ready_c;
  logic             out_valid_c;
  logic             busy_c;

  // Lengths beyond the maximum are clamped so cnt can never wrap.
  assign len_sat = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      fx_q    <= '0;
      fy_q    <= '0;
      fz_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      fz_q    <= fz_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    tgt_d       = tgt_q;
    fx_d        = fx_q;
    fy_d        = fy_q;
    fz_d        = fz_q;
    ovf_d       = ovf_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy_c = 1'b0;
        if (bus.start) begin
          acc_d   = bus.init_z;
          cnt_d   = '0;
          tgt_d   = len_sat;
          ovf_d   = 1'b0;
          state_d = (len_sat == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          fx_d    = bus.in_x;
          fy_d    = bus.in_y;
          fz_d    = acc_q;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        // The FMAC is combinational, so its result is ready one cycle after the operand load.
        acc_d = bus.fmac_result;
        cnt_d = cnt_inc;
        if (bus.fmac_result[14:10] == 5'h1F) begin
          ovf_d = 1'b1;
        end
        state_d = (cnt_inc == tgt_q) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.out_data  = acc_q;
  assign bus.fmac_x    = fx_q;
  assign bus.fmac_y    = fy_q;
  assign bus.fmac_z    = fz_q;
  assign bus.ovf       = ovf_q;

endmodule
